// File: rtl/dmem_port_arbiter.sv
// Single-port data-memory controller: arbitrates the memory port between loads and an
// in-order committed-store queue, with youngest-match store-to-load forwarding.
module dmem_port_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int TAG_W      = 4,
    parameter int SQ_DEPTH   = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [TAG_W-1:0]  ld_tag,
    output logic              ld_resp_valid,
    output logic [TAG_W-1:0]  ld_resp_tag,
    output logic [DATA_W-1:0] ld_resp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sq_empty
);

    localparam int PTR_W = $clog2(SQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SV_W  = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(SQ_DEPTH);
    localparam logic [SV_W-1:0]  STARVE_LIM = SV_W'(STARVE_MAX);

    logic [ADDR_W-1:0] sq_addr [SQ_DEPTH];
    logic [DATA_W-1:0] sq_data [SQ_DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic [SV_W-1:0]   starve_cnt;

    logic              resp_valid_q;
    logic              resp_miss_q;
    logic [TAG_W-1:0]  resp_tag_q;
    logic [DATA_W-1:0] resp_data_q;

    logic              force_drain;
    logic              ld_acc;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              grant_rd;
    logic              drain;
    logic              push;

    assign force_drain = (count == FULL_CNT) || (count != '0 && starve_cnt == STARVE_LIM);
    assign ld_ready    = !flush && !force_drain;
    assign st_ready    = (count != FULL_CNT);
    assign sq_empty    = (count == '0);

    assign ld_acc   = ld_valid && ld_ready;
    assign push     = st_valid && st_ready;
    assign grant_rd = ld_acc && !fwd_hit;
    assign drain    = !grant_rd && (count != '0);

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count && sq_addr[idx] == ld_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = sq_data[idx];
            end
        end
    end

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_rd) begin
            mem_en   = 1'b1;
            mem_addr = ld_addr;
        end else if (drain) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sq_addr[head];
            mem_wdata = sq_data[head];
        end
    end

    // NOTE: queue storage has no reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            sq_addr[tail] <= st_addr;
            sq_data[tail] <= st_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all regs update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            starve_cnt   <= '0;
            resp_valid_q <= 1'b0;
            resp_miss_q  <= 1'b0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            if (push)  tail <= tail + PTR_W'(1);
            if (drain) head <= head + PTR_W'(1);
            if (push && !drain)      count <= count + CNT_W'(1);
            else if (!push && drain) count <= count - CNT_W'(1);

            if (grant_rd && count != '0) begin
                if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + SV_W'(1);
            end else if (drain || count == '0) begin
                starve_cnt <= '0;
            end

            resp_valid_q <= ld_acc;
            resp_miss_q  <= grant_rd;
            if (ld_acc) resp_tag_q <= ld_tag;
            if (ld_acc && fwd_hit) resp_data_q <= fwd_data;
        end
    end

    // A flush squashes the response of the load accepted just before it.
    assign ld_resp_valid = resp_valid_q && !flush;
    assign ld_resp_tag   = resp_tag_q;
    assign ld_resp_data  = resp_miss_q ? mem_rdata : resp_data_q;

endmodule
